cpu_control_fsm: RTL

Multi-cycle control state machine for the CR16-style core. It consumes the instruction register and PSR held by the processor-register block, and generates that block's load enables (pc_en, instr_en, cmp_f_en, of_f_en, z_f_en). It also drives the register-file, ALU, memory and next-PC select controls. Branch and jump conditions are evaluated here from PSR flags.

---
 rtl/cpu_defs.sv | 115 +++++++++++
 rtl/cond_eval.sv | 47 ++++
 rtl/cpu_control_fsm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the CR16-style control path.
//   - FSM state enum, ALU operation enum
//   - opcode / extension field constants, condition-code constants
//   - PSR flag bit positions, pc_sel / wb_sel encodings
//   - ctrl_t: bundle of every control output driven by the FSM
package cpu_defs;

    localparam int CPU_INSTR_W  = 16;
    localparam int CPU_ALU_OP_W = 4;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_LOAD_IR = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM_RD  = 3'd3,
        S_WB_LD   = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    typedef enum logic [CPU_ALU_OP_W-1:0] {
        ALU_NOP = 4'd0,
        ALU_AND = 4'd1,
        ALU_OR  = 4'd2,
        ALU_XOR = 4'd3,
        ALU_ADD = 4'd4,
        ALU_SUB = 4'd5,
        ALU_CMP = 4'd6,
        ALU_MOV = 4'd7,
        ALU_LSH = 4'd8,
        ALU_LUI = 4'd9
    } alu_op_e;

    // ALU function codes: appear in ext for R-type, in op for immediates
    localparam logic [3:0] FN_AND = 4'b0001;
    localparam logic [3:0] FN_OR  = 4'b0010;
    localparam logic [3:0] FN_XOR = 4'b0011;
    localparam logic [3:0] FN_ADD = 4'b0101;
    localparam logic [3:0] FN_SUB = 4'b1001;
    localparam logic [3:0] FN_CMP = 4'b1011;
    localparam logic [3:0] FN_MOV = 4'b1101;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_LSH   = 4'b1000;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] EXT_LOAD    = 4'b0000;
    localparam logic [3:0] EXT_STOR    = 4'b0100;
    localparam logic [3:0] EXT_JAL     = 4'b1000;
    localparam logic [3:0] EXT_JCOND   = 4'b1100;
    localparam logic [3:0] EXT_LSH_REG = 4'b0100;

    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    localparam logic [1:0] PC_SEL_INC  = 2'd0;
    localparam logic [1:0] PC_SEL_DISP = 2'd1;
    localparam logic [1:0] PC_SEL_REG  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    typedef struct packed {
        logic       pc_en;
        logic       instr_en;
        logic       cmp_f_en;
        logic       of_f_en;
        logic       z_f_en;
        logic [1:0] pc_sel;
        logic       rf_wr_en;
        logic [1:0] wb_sel;
        alu_op_e    alu_op;
        logic       src_imm;
        logic       mem_addr_sel;
        logic       mem_we;
        logic       halted;
    } ctrl_t;

    function automatic logic is_alu_code(input logic [3:0] code);
        case (code)
            FN_AND, FN_OR, FN_XOR, FN_ADD, FN_SUB, FN_CMP, FN_MOV: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

    // Controls for one ALU-class instruction; pc_en is added by the caller.
    function automatic ctrl_t alu_ctrl(input logic [3:0] code, input logic imm);
        ctrl_t r;
        r          = '0;
        r.src_imm  = imm;
        r.rf_wr_en = (code != FN_CMP);
        case (code)
            FN_AND:  begin r.alu_op = ALU_AND; r.z_f_en = 1'b1; end
            FN_OR:   begin r.alu_op = ALU_OR;  r.z_f_en = 1'b1; end
            FN_XOR:  begin r.alu_op = ALU_XOR; r.z_f_en = 1'b1; end
            FN_ADD:  begin r.alu_op = ALU_ADD; r.of_f_en = 1'b1; r.z_f_en = 1'b1; end
            FN_SUB:  begin r.alu_op = ALU_SUB; r.of_f_en = 1'b1; r.z_f_en = 1'b1; end
            FN_CMP:  begin r.alu_op = ALU_CMP; r.cmp_f_en = 1'b1; r.z_f_en = 1'b1; end
            FN_MOV:  r.alu_op = ALU_MOV;
            default: r.alu_op = ALU_NOP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational branch/jump condition evaluation.
//   cond_i [3:0]  condition code from instr[11:8]
//   psr_i  [15:0] processor status (C, L, F, Z, N flags)
//   take_o        1 = condition holds
module cond_eval
    import cpu_defs::*;
(
    input  logic [3:0]             cond_i,
    input  logic [CPU_INSTR_W-1:0] psr_i,
    output logic                   take_o
);

    logic c, l, f, z, n;

    assign c = psr_i[PSR_C];
    assign l = psr_i[PSR_L];
    assign f = psr_i[PSR_F];
    assign z = psr_i[PSR_Z];
    assign n = psr_i[PSR_N];

    always_comb begin
        take_o = 1'b0;
        case (cond_i)
            CC_EQ:   take_o = z;
            CC_NE:   take_o = !z;
            CC_CS:   take_o = c;
            CC_CC:   take_o = !c;
            CC_HI:   take_o = l;
            CC_LS:   take_o = !l;
            CC_GT:   take_o = n;
            CC_LE:   take_o = !n;
            CC_FS:   take_o = f;
            CC_FC:   take_o = !f;
            CC_LO:   take_o = !l && !z;
            CC_HS:   take_o = l || z;
            CC_LT:   take_o = !n && !z;
            CC_GE:   take_o = n || z;
            CC_UC:   take_o = 1'b1;
            default: take_o = 1'b0;
        endcase
    end

    // Remaining PSR bits carry no condition information
    logic unused_psr;
    assign unused_psr = ^{psr_i[15:8], psr_i[4:3], psr_i[1]};

endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control FSM for the CR16-style core.
//   clk, reset   clock; synchronous active-high reset
//   run          allows leaving S_FETCH
//   instr, psr   instruction register and status register contents
//   pc_en, instr_en, cmp_f_en, of_f_en, z_f_en   processor-register load enables
//   pc_sel, rf_wr_en, wb_sel, alu_op, src_imm    next-PC / register-file / ALU controls
//   mem_addr_sel, mem_we                         memory address select and write strobe
//   halted       illegal opcode trapped (cleared only by reset)
module cpu_control_fsm
    import cpu_defs::*;
#(
    parameter int INSTR_W  = CPU_INSTR_W,
    parameter int ALU_OP_W = CPU_ALU_OP_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [INSTR_W-1:0]  psr,
    output logic                pc_en,
    output logic                instr_en,
    output logic                cmp_f_en,
    output logic                of_f_en,
    output logic                z_f_en,
    output logic [1:0]          pc_sel,
    output logic                rf_wr_en,
    output logic [1:0]          wb_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                src_imm,
    output logic                mem_addr_sel,
    output logic                mem_we,
    output logic                halted
);

    state_e     state_q, state_d;
    ctrl_t      ctrl;
    logic       illegal;
    logic       take;
    logic [3:0] op, ext;

    assign op  = instr[15:12];
    assign ext = instr[7:4];

    cond_eval u_cond (
        .cond_i (instr[11:8]),
        .psr_i  (psr[CPU_INSTR_W-1:0]),
        .take_o (take)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) state_d = S_LOAD_IR;
            end
            S_LOAD_IR: begin
                ctrl.instr_en = 1'b1;
                state_d       = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (op == OP_RTYPE) begin
                    if (is_alu_code(ext)) ctrl = alu_ctrl(ext, 1'b0);
                    else                  illegal = 1'b1;
                end else if (is_alu_code(op)) begin
                    // Immediate form: the op field doubles as the ALU function code
                    ctrl = alu_ctrl(op, 1'b1);
                end else begin
                    case (op)
                        OP_LSH: begin
                            if (ext == EXT_LSH_REG) begin
                                ctrl.rf_wr_en = 1'b1;
                                ctrl.alu_op   = ALU_LSH;
                            end else if (ext[3:1] == 3'b000) begin
                                ctrl.rf_wr_en = 1'b1;
                                ctrl.alu_op   = ALU_LSH;
                                ctrl.src_imm  = 1'b1;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                        OP_LUI: begin
                            ctrl.rf_wr_en = 1'b1;
                            ctrl.alu_op   = ALU_LUI;
                            ctrl.src_imm  = 1'b1;
                        end
                        OP_BCOND: ctrl.pc_sel = take ? PC_SEL_DISP : PC_SEL_INC;
                        OP_MEM: begin
                            case (ext)
                                EXT_LOAD: begin
                                    ctrl.mem_addr_sel = 1'b1;
                                    state_d           = S_MEM_RD;
                                end
                                EXT_STOR: begin
                                    ctrl.mem_addr_sel = 1'b1;
                                    ctrl.mem_we       = 1'b1;
                                end
                                EXT_JCOND: ctrl.pc_sel = take ? PC_SEL_REG : PC_SEL_INC;
                                EXT_JAL: begin
                                    ctrl.rf_wr_en = 1'b1;
                                    ctrl.wb_sel   = WB_LINK;
                                    ctrl.pc_sel   = PC_SEL_REG;
                                end
                                default: illegal = 1'b1;
                            endcase
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                // LOAD defers the PC update to S_WB_LD; illegal traps with nothing enabled
                if (illegal) begin
                    ctrl    = '0;
                    state_d = S_HALT;
                end else if (state_d != S_MEM_RD) begin
                    ctrl.pc_en = 1'b1;
                end
            end
            S_MEM_RD: begin
                ctrl.mem_addr_sel = 1'b1;
                state_d           = S_WB_LD;
            end
            S_WB_LD: begin
                ctrl.rf_wr_en = 1'b1;
                ctrl.wb_sel   = WB_MEM;
                ctrl.pc_en    = 1'b1;
                ctrl.pc_sel   = PC_SEL_INC;
                state_d       = S_FETCH;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pc_en        = ctrl.pc_en;
    assign instr_en     = ctrl.instr_en;
    assign cmp_f_en     = ctrl.cmp_f_en;
    assign of_f_en      = ctrl.of_f_en;
    assign z_f_en       = ctrl.z_f_en;
    assign pc_sel       = ctrl.pc_sel;
    assign rf_wr_en     = ctrl.rf_wr_en;
    assign wb_sel       = ctrl.wb_sel;
    assign alu_op       = ALU_OP_W'(ctrl.alu_op);
    assign src_imm      = ctrl.src_imm;
    assign mem_addr_sel = ctrl.mem_addr_sel;
    assign mem_we       = ctrl.mem_we;
    assign halted       = ctrl.halted;

    // Register addresses in instr[3:0] are consumed by the datapath, not here
    logic unused_instr;
    assign unused_instr = ^instr[3:0];

endmodule
